tdc_sum_tree: RTL and testbench

Parametrised, fully pipelined channel combiner for the TDC datapath. Each enabled channel's coarse count is scaled by a fixed fine-per-coarse weight and added to its fine code. All channel terms are summed in a registered adder tree of configurable depth. An optional block accumulator then averages 2^k consecutive sums. It sits between the per-channel coarse/fine capture logic and the result FIFO, and accepts one sample per clock.

---
 rtl/tdc_sum_tree.sv | 142 ++++++++++++++
 tb/tb_tdc_sum_tree.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_sum_tree.sv
// tdc_sum_tree: weights coarse+fine per channel, sums them through a registered adder tree,
// then optionally averages blocks of 2^k consecutive sums.
module tdc_sum_tree #(
    parameter int N_CH = 8,
    parameter int INT_W = 10,
    parameter int FRAC_W = 7,
    parameter int MULT = 50,
    parameter int ACC_LOG2_MAX = 8,
    localparam int TW = $clog2((2**INT_W - 1) * MULT + 2**FRAC_W),
    localparam int L = $clog2(N_CH),
    localparam int SUM_W = TW + L,
    localparam int ACC_W = SUM_W + ACC_LOG2_MAX,
    localparam int KW = (ACC_LOG2_MAX > 0) ? $clog2(ACC_LOG2_MAX + 1) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [INT_W-1:0]  int_data [N_CH],
    input  logic [FRAC_W-1:0] frac_data [N_CH],
    input  logic [N_CH-1:0]   ch_mask,
    input  logic [KW-1:0]     acc_log2,
    input  logic              clr,
    output logic [SUM_W-1:0]  sum_out,
    output logic              sum_dval,
    output logic [ACC_W-1:0]  acc_out,
    output logic [SUM_W-1:0]  mean_out,
    output logic              acc_dval
);
    localparam int P = 2**L;
    localparam int CW = ACC_LOG2_MAX + 1;

    logic [INT_W-1:0]  int_q [N_CH];
    logic [FRAC_W-1:0] frac_q [N_CH];
    logic [N_CH-1:0]   mask_q;
    logic              v0;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            v0 <= 1'b0;
            mask_q <= '0;
            for (int g = 0; g < N_CH; g++) begin
                int_q[g] <= '0;
                frac_q[g] <= '0;
            end
        end else begin
            v0 <= start && !clr;
            if (start && !clr) begin
                int_q <= int_data;
                frac_q <= frac_data;
                mask_q <= ch_mask;
            end
        end

    // Level 0 holds the channel terms (zero-padded to a power of two); level l sums pairs of level l-1.
    for (genvar l = 0; l <= L; l++) begin : lv
        localparam int W = TW + l;
        logic [W-1:0] s [P>>l];
        logic         v;
        if (l == 0) begin : b
            always_ff @(posedge clk or negedge rst)
                if (!rst) v <= 1'b0;
                else v <= v0 && !clr;
            for (genvar j = 0; j < P; j++) begin : n
                if (j < N_CH) begin : t
                    logic [TW-1:0] r;
                    always_ff @(posedge clk or negedge rst)
                        if (!rst) r <= '0;
                        else if (v0 && !clr) r <= mask_q[j] ? TW'(int_q[j]) * TW'(MULT) + TW'(frac_q[j]) : '0;
                    assign s[j] = r;
                end else begin : z
                    assign s[j] = '0;
                end
            end
        end else begin : b
            always_ff @(posedge clk or negedge rst)
                if (!rst) v <= 1'b0;
                else v <= lv[l-1].v && !clr;
            for (genvar j = 0; j < (P>>l); j++) begin : n
                logic [W-1:0] r;
                always_ff @(posedge clk or negedge rst)
                    if (!rst) r <= '0;
                    else if (lv[l-1].v && !clr) r <= W'(lv[l-1].s[2*j]) + W'(lv[l-1].s[2*j+1]);
                assign s[j] = r;
            end
        end
    end

    assign sum_out = lv[L].s[0];
    assign sum_dval = lv[L].v;

    typedef enum logic {IDLE, ACC} state_t;
    state_t         state, state_d;
    logic [KW-1:0]  k_q, k_d, k_in;
    logic [ACC_W-1:0] acc, acc_d, acc_sum;
    logic [CW-1:0]  cnt, cnt_d;
    logic           pub;

    assign k_in = (acc_log2 > KW'(ACC_LOG2_MAX)) ? KW'(ACC_LOG2_MAX) : acc_log2;
    assign acc_sum = acc + ACC_W'(sum_out);

    // Publishing happens on the completing sample itself, so the FSM is already IDLE for the next sum.
    always_comb begin
        state_d = state;
        k_d = k_q;
        acc_d = acc;
        cnt_d = cnt;
        pub = 1'b0;
        if (sum_dval) begin
            k_d = (state == IDLE) ? k_in : k_q;
            acc_d = (state == IDLE) ? ACC_W'(sum_out) : acc_sum;
            cnt_d = (state == IDLE) ? CW'(1) : cnt + CW'(1);
            pub = (state == IDLE) ? (k_in == '0) : (cnt_d == (CW'(1) << k_q));
            state_d = pub ? IDLE : ACC;
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            k_q <= '0;
            acc <= '0;
            cnt <= '0;
            acc_out <= '0;
            mean_out <= '0;
            acc_dval <= 1'b0;
        end else if (clr) begin
            state <= IDLE;
            acc <= '0;
            cnt <= '0;
            acc_dval <= 1'b0;
        end else begin
            state <= state_d;
            k_q <= k_d;
            acc <= acc_d;
            cnt <= cnt_d;
            acc_dval <= pub;
            if (pub) begin
                acc_out <= acc_d;
                mean_out <= SUM_W'(acc_d >> k_d);
            end
        end
endmodule

// File: tb/tb_tdc_sum_tree.sv
// tb_tdc_sum_tree: randomized and directed checks of tdc_sum_tree against a plain-arithmetic
// model of channel sums and 2^k block averages.
module tb_tdc_sum_tree;
    localparam int LAT = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, clr;
    logic [9:0]  int_data [0:7];
    logic [6:0]  frac_data [0:7];
    logic [7:0]  ch_mask;
    logic [3:0]  acc_log2;
    logic [18:0] sum_out, mean_out;
    logic [26:0] acc_out;
    logic        sum_dval, acc_dval;

    logic        start5, clr5;
    logic [9:0]  int5 [0:4];
    logic [6:0]  frac5 [0:4];
    logic [4:0]  mask5;
    logic [3:0]  acc5;
    logic [13:0] sum5, mean5;
    logic [21:0] acc_out5;
    logic        sum_dval5, acc_dval5;

    tdc_sum_tree dut (
        .clk(clk), .rst(rst), .start(start), .int_data(int_data), .frac_data(frac_data),
        .ch_mask(ch_mask), .acc_log2(acc_log2), .clr(clr), .sum_out(sum_out), .sum_dval(sum_dval),
        .acc_out(acc_out), .mean_out(mean_out), .acc_dval(acc_dval)
    );

    tdc_sum_tree #(.N_CH(5), .MULT(1)) u5 (
        .clk(clk), .rst(rst), .start(start5), .int_data(int5), .frac_data(frac5),
        .ch_mask(mask5), .acc_log2(acc5), .clr(clr5), .sum_out(sum5), .sum_dval(sum_dval5),
        .acc_out(acc_out5), .mean_out(mean5), .acc_dval(acc_dval5)
    );

    int tests = 0;
    int fails = 0;

    logic [9:0] s_int [0:299][0:7];
    logic [6:0] s_frac [0:299][0:7];
    logic [7:0] s_mask [0:299];
    int         s_gap [0:299];
    int         dc [0:299];
    bit         w_v [0:2047];
    bit         w_a [0:2047];
    longint     w_s [0:2047];
    longint     w_acc [0:2047];
    longint     w_mean [0:2047];

    function automatic longint ref_sum(input int i);
        longint s = 0;
        for (int g = 0; g < 8; g++)
            if (s_mask[i][g]) s += longint'(s_int[i][g]) * 50 + longint'(s_frac[i][g]);
        return s;
    endfunction

    task automatic set_smp(input int i, input int iv, input int fv, input int mk, input int gp);
        for (int g = 0; g < 8; g++) begin
            s_int[i][g] = 10'(iv);
            s_frac[i][g] = 7'(fv);
        end
        s_mask[i] = 8'(mk);
        s_gap[i] = gp;
    endtask

    task automatic do_clr();
        @(negedge clk);
        start = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Drives samples 0..n-1 after their gaps; expects each sum LAT cycles after its start and
    // a block result one cycle after every 2^k-th sum (k clamped to 8). Assumes an idle DUT.
    task automatic run_stream(input string nm, input int n, input int k);
        int kk, bn, j, t_end;
        longint bs;
        kk = (k > 8) ? 8 : k;
        for (int t = 0; t < 2048; t++) begin
            w_v[t] = 1'b0;
            w_a[t] = 1'b0;
        end
        bs = 0;
        bn = 0;
        for (int i = 0; i < n; i++) begin
            dc[i] = (i == 0) ? 0 : dc[i-1] + 1 + s_gap[i];
            w_v[dc[i] + LAT] = 1'b1;
            w_s[dc[i] + LAT] = ref_sum(i);
            bs += ref_sum(i);
            bn++;
            if (bn == (1 << kk)) begin
                w_a[dc[i] + LAT + 1] = 1'b1;
                w_acc[dc[i] + LAT + 1] = bs;
                w_mean[dc[i] + LAT + 1] = bs >> kk;
                bs = 0;
                bn = 0;
            end
        end
        t_end = dc[n-1] + LAT + 3;
        acc_log2 = 4'(k);
        j = 0;
        for (int t = 0; t <= t_end; t++) begin
            @(negedge clk);
            tests++;
            if (sum_dval !== w_v[t]) begin
                fails++;
                $display("FAIL %s sum_dval t=%0d got %b want %b", nm, t, sum_dval, w_v[t]);
            end
            if (w_v[t]) begin
                tests++;
                if (sum_out !== w_s[t]) begin
                    fails++;
                    $display("FAIL %s sum_out t=%0d got %0d want %0d", nm, t, sum_out, w_s[t]);
                end
            end
            tests++;
            if (acc_dval !== w_a[t]) begin
                fails++;
                $display("FAIL %s acc_dval t=%0d got %b want %b", nm, t, acc_dval, w_a[t]);
            end
            if (w_a[t]) begin
                tests += 2;
                if (acc_out !== w_acc[t]) begin
                    fails++;
                    $display("FAIL %s acc_out t=%0d got %0d want %0d", nm, t, acc_out, w_acc[t]);
                end
                if (mean_out !== w_mean[t]) begin
                    fails++;
                    $display("FAIL %s mean_out t=%0d got %0d want %0d", nm, t, mean_out, w_mean[t]);
                end
            end
            if (j < n && dc[j] == t) begin
                int_data = s_int[j];
                frac_data = s_frac[j];
                ch_mask = s_mask[j];
                start = 1'b1;
                j++;
            end else start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests += 6;
        if (sum_out !== 0 || sum_dval !== 0) begin
            fails++;
            $display("FAIL reset sum got %0d/%b want 0/0", sum_out, sum_dval);
        end
        if (acc_out !== 0) begin
            fails++;
            $display("FAIL reset acc_out got %0d want 0", acc_out);
        end
        if (mean_out !== 0) begin
            fails++;
            $display("FAIL reset mean_out got %0d want 0", mean_out);
        end
        if (acc_dval !== 0) begin
            fails++;
            $display("FAIL reset acc_dval got %b want 0", acc_dval);
        end
        if (sum5 !== 0 || sum_dval5 !== 0) begin
            fails++;
            $display("FAIL reset u5 got %0d/%b want 0/0", sum5, sum_dval5);
        end
        if (acc_out5 !== 0) begin
            fails++;
            $display("FAIL reset u5 acc_out got %0d want 0", acc_out5);
        end
        rst = 1'b1;
    endtask

    task automatic test_all_channels();
        do_clr();
        set_smp(0, 100, 10, 'hFF, 0);
        run_stream("all_ch", 1, 0);
    endtask

    task automatic test_mask_extremes();
        do_clr();
        set_smp(0, 1023, 127, 'h01, 0);
        set_smp(1, 1023, 127, 'h00, 2);
        run_stream("mask", 2, 0);
    endtask

    task automatic test_back_to_back();
        do_clr();
        for (int i = 0; i < 16; i++) begin
            set_smp(i, 0, 0, 'hFF, 0);
            for (int g = 0; g < 8; g++) s_int[i][g] = 10'(g + i);
        end
        run_stream("stream", 16, 4);
    endtask

    task automatic test_accum();
        do_clr();
        for (int i = 0; i < 8; i++) begin
            set_smp(i, 100, 10, 'hFF, (i == 0 || i == 4) ? 0 : $urandom_range(0, 3));
            s_frac[i][0] = (i < 4) ? 7'(10 + i) : 7'($urandom);
        end
        run_stream("accum", 8, 2);
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 6; r++) begin
            do_clr();
            n = $urandom_range(4, 40);
            for (int i = 0; i < n; i++) begin
                for (int g = 0; g < 8; g++) begin
                    s_int[i][g] = 10'($urandom);
                    s_frac[i][g] = 7'($urandom);
                end
                s_mask[i] = 8'($urandom);
                s_gap[i] = $urandom_range(0, 1) ? 0 : $urandom_range(1, 3);
            end
            run_stream("random", n, $urandom_range(0, 3));
        end
    endtask

    task automatic test_clamp();
        do_clr();
        for (int i = 0; i < 256; i++) begin
            for (int g = 0; g < 8; g++) begin
                s_int[i][g] = 10'($urandom);
                s_frac[i][g] = 7'($urandom);
            end
            s_mask[i] = 8'($urandom);
            s_gap[i] = 0;
        end
        run_stream("clamp", 256, 15);
    endtask

    task automatic test_flush();
        bit ev, ea;
        longint es;
        do_clr();
        acc_log2 = 4'd1;
        for (int g = 0; g < 8; g++) begin
            int_data[g] = 10'd100;
            frac_data[g] = 7'd10;
        end
        ch_mask = 8'hFF;
        for (int t = 0; t <= 24; t++) begin
            @(negedge clk);
            ev = (t == 5 || t == 20 || t == 21);
            es = (t == 5) ? 40080 : (t == 20) ? 40081 : 40083;
            ea = (t == 22);
            tests += 2;
            if (sum_dval !== ev) begin
                fails++;
                $display("FAIL flush sum_dval t=%0d got %b want %b", t, sum_dval, ev);
            end
            if (acc_dval !== ea) begin
                fails++;
                $display("FAIL flush acc_dval t=%0d got %b want %b", t, acc_dval, ea);
            end
            if (ev) begin
                tests++;
                if (sum_out !== es) begin
                    fails++;
                    $display("FAIL flush sum_out t=%0d got %0d want %0d", t, sum_out, es);
                end
            end
            if (ea) begin
                tests += 2;
                if (acc_out !== 80164) begin
                    fails++;
                    $display("FAIL flush acc_out got %0d want 80164", acc_out);
                end
                if (mean_out !== 40082) begin
                    fails++;
                    $display("FAIL flush mean_out got %0d want 40082", mean_out);
                end
            end
            start = (t == 0 || t == 6 || t == 15 || t == 16);
            clr = (t == 8);
            frac_data[0] = (t == 15) ? 7'd11 : (t == 16) ? 7'd13 : 7'd10;
        end
        start = 1'b0;
        clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_clr();
        acc_log2 = 4'd3;
        for (int g = 0; g < 8; g++) begin
            int_data[g] = 10'($urandom);
            frac_data[g] = 7'($urandom);
        end
        ch_mask = 8'hFF;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            start = (t < 5);
        end
        rst = 1'b0;
        @(negedge clk);
        tests += 5;
        if (sum_out !== 0) begin
            fails++;
            $display("FAIL rst_mid sum_out got %0d want 0", sum_out);
        end
        if (sum_dval !== 0) begin
            fails++;
            $display("FAIL rst_mid sum_dval got %b want 0", sum_dval);
        end
        if (acc_out !== 0) begin
            fails++;
            $display("FAIL rst_mid acc_out got %0d want 0", acc_out);
        end
        if (mean_out !== 0) begin
            fails++;
            $display("FAIL rst_mid mean_out got %0d want 0", mean_out);
        end
        if (acc_dval !== 0) begin
            fails++;
            $display("FAIL rst_mid acc_dval got %b want 0", acc_dval);
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_smp(i, 0, 0, 'hFF, $urandom_range(0, 2));
            for (int g = 0; g < 8; g++) s_int[i][g] = 10'($urandom);
        end
        run_stream("post_rst", 8, 3);
    endtask

    task automatic test_odd_channels();
        longint es;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            es = 0;
            for (int g = 0; g < 5; g++) begin
                int5[g] = (r == 0) ? 10'd1 : 10'($urandom);
                frac5[g] = (r == 0) ? 7'd1 : 7'($urandom);
            end
            mask5 = (r == 0) ? 5'h1F : 5'($urandom);
            for (int g = 0; g < 5; g++) if (mask5[g]) es += longint'(int5[g]) + longint'(frac5[g]);
            start5 = 1'b1;
            for (int t = 1; t <= 7; t++) begin
                @(negedge clk);
                start5 = 1'b0;
                tests++;
                if (sum_dval5 !== (t == 5)) begin
                    fails++;
                    $display("FAIL odd sum_dval t=%0d got %b want %b", t, sum_dval5, t == 5);
                end
                if (t == 5) begin
                    tests++;
                    if (sum5 !== es) begin
                        fails++;
                        $display("FAIL odd sum_out got %0d want %0d", sum5, es);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        clr = 1'b0;
        ch_mask = '0;
        acc_log2 = '0;
        start5 = 1'b0;
        clr5 = 1'b0;
        mask5 = '0;
        acc5 = '0;
        for (int g = 0; g < 8; g++) begin
            int_data[g] = '0;
            frac_data[g] = '0;
        end
        for (int g = 0; g < 5; g++) begin
            int5[g] = '0;
            frac5[g] = '0;
        end
        test_reset();
        test_all_channels();
        test_mask_extremes();
        test_back_to_back();
        test_accum();
        test_flush();
        test_random();
        test_clamp();
        test_reset_mid();
        test_odd_channels();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
